// File: rtl/barrel_arbiter.sv
// Round-robin front end sharing one registered barrel right-shifter
// between NREQ requesters; results return tagged with the requester ID.
module barrel_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 64,
  parameter int SHIFT_MAX   = 46,
  parameter int SHIFT_WIDTH = $clog2(SHIFT_MAX + 2),
  parameter int ID_WIDTH    = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_signed,
  input  logic [NREQ*SHIFT_WIDTH-1:0] req_shift,
  input  logic [NREQ*WIDTH-1:0]       req_in,
  input  logic [NREQ*WIDTH-1:0]       req_ex,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [WIDTH-1:0]            rsp_data,
  output logic                        busy
);

  localparam logic [SHIFT_WIDTH-1:0] SEL_EX =
    SHIFT_WIDTH'(SHIFT_MAX + 1);
  localparam bit CLAMP = (2 ** SHIFT_WIDTH) > (SHIFT_MAX + 2);

  if (SHIFT_WIDTH < $clog2(SHIFT_MAX + 2) || NREQ < 2) begin : g_bad_cfg
    $fatal(1, "barrel_arbiter: illegal NREQ/SHIFT_WIDTH");
  end

  logic                   advance;
  logic                   hit;
  logic                   hs;
  logic [ID_WIDTH-1:0]    gnt;
  logic [ID_WIDTH-1:0]    ptr;

  logic                   s1_valid;
  logic [ID_WIDTH-1:0]    s1_id;
  logic                   s2_valid;
  logic [ID_WIDTH-1:0]    s2_id;

  logic                   mux_signed;
  logic [SHIFT_WIDTH-1:0] mux_shift;
  logic [SHIFT_WIDTH-1:0] iss_shift;
  logic [WIDTH-1:0]       mux_in;
  logic [WIDTH-1:0]       mux_ex;

  logic                   a_signed;
  logic [SHIFT_WIDTH-1:0] a_shift;
  logic [WIDTH-1:0]       a_in;
  logic [WIDTH-1:0]       a_ex;
  logic                   fill;
  logic [WIDTH-1:0]       res;

  assign advance = !s2_valid || rsp_ready;

  // first valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin : arb
    int idx;
    hit = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gnt = ID_WIDTH'(idx);
      end
    end
  end

  assign hs = hit && advance && !srst;

  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    mux_signed = 1'b0;
    mux_shift  = '0;
    mux_in     = '0;
    mux_ex     = '0;
    if (hit) begin
      mux_signed = req_signed[gnt];
      mux_shift  = req_shift[int'(gnt)*SHIFT_WIDTH +: SHIFT_WIDTH];
      mux_in     = req_in[int'(gnt)*WIDTH +: WIDTH];
      mux_ex     = req_ex[int'(gnt)*WIDTH +: WIDTH];
    end
  end

  if (CLAMP) begin : g_clamp
    assign iss_shift = (mux_shift > SEL_EX) ? SEL_EX : mux_shift;
  end else begin : g_noclamp
    assign iss_shift = mux_shift;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
    end else if (advance) begin
      s1_valid <= hs;
      s1_id    <= gnt;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (hs) begin
        ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  // datapath carries no reset; validity lives in the tag pipeline
  always_ff @(posedge clk) begin
    if (advance) begin
      a_signed <= mux_signed;
      a_shift  <= iss_shift;
      a_in     <= mux_in;
      a_ex     <= mux_ex;
      rsp_data <= res;
    end
  end

  always_comb begin
    fill = a_signed & a_in[WIDTH-1];
    res  = WIDTH'($signed({fill, a_in}) >>> a_shift);
    if (a_shift == SEL_EX) begin
      res = a_ex;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_barrel_arbiter.sv
// Bench for barrel_arbiter: vector table, round-robin and
// stall/reset sequences, checked by an arbiter model plus result queue.
module tb_barrel_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int SW = 6;

  typedef struct {
    int          rq;
    bit          sg;
    logic [5:0]  sh;
    logic [63:0] din;
    logic [63:0] ex;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } rsp_t;

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_signed;
  logic [N*SW-1:0] req_shift;
  logic [N*W-1:0]  req_in;
  logic [N*W-1:0]  req_ex;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            busy;

  logic [63:0] drv_exp [N];
  rsp_t        q [$];
  vec_t        tbl [11];

  int n_chk  = 0;
  int n_fail = 0;

  int  m_ptr;
  bit  m_v1;
  bit  m_v2;

  barrel_arbiter dut (
    .clk       (clk),
    .srst      (srst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_signed(req_signed),
    .req_shift (req_shift),
    .req_in    (req_in),
    .req_ex    (req_ex),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg,
    input logic [5:0] sh, input logic [63:0] din,
    input logic [63:0] ex);
    if (sh == 6'd0) return din;
    if (sh >= 6'd47) return ex;
    if (sg && din[63]) return ~((~din) >> sh);
    return din >> sh;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit sg,
    input logic [5:0] sh, input logic [63:0] din,
    input logic [63:0] ex, input logic [63:0] e);
    req_signed[i]         = sg;
    req_shift[i*SW +: SW] = sh;
    req_in[i*W +: W]      = din;
    req_ex[i*W +: W]      = ex;
    drv_exp[i]            = e;
    req_valid[i]          = 1'b1;
  endtask

  task automatic issue_one(input int rq, input bit sg,
    input logic [5:0] sh, input logic [63:0] din,
    input logic [63:0] ex, input logic [63:0] e);
    bit done;
    done = 1'b0;
    set_req(rq, sg, sh, din, ex, e);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready[rq]) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: req %0d got no ready, expected ready", rq);
    end
    cyc();
    req_valid[rq] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      cyc();
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending, expected 0", q.size());
    end
    repeat (2) cyc();
  endtask

  // arbiter/pipeline model and result scoreboard, sampled mid-cycle
  initial begin : mon
    bit         adv;
    bit         hit;
    int         g;
    int         idx;
    logic [3:0] er;
    rsp_t       r;
    m_ptr = 0;
    m_v1  = 1'b0;
    m_v2  = 1'b0;
    forever begin
      @(negedge clk);
      if (srst) begin
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        m_ptr = 0;
        m_v1  = 1'b0;
        m_v2  = 1'b0;
        q.delete();
      end else begin
        adv = !m_v2 || rsp_ready;
        hit = 1'b0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!hit && req_valid[idx]) begin
            hit = 1'b1;
            g   = idx;
          end
        end
        er = (hit && adv) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_v2));
        chk("busy", 64'(busy), 64'(m_v1 || m_v2));
        if (m_v2) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got response, expected none");
          end else begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_data", rsp_data, q[0].data);
            if (rsp_ready) r = q.pop_front();
          end
        end
        if (adv) begin
          m_v2 = m_v1;
          m_v1 = hit;
          if (hit) begin
            r.id   = 2'(g);
            r.data = drv_exp[g];
            q.push_back(r);
            m_ptr = (g + 1) % N;
          end
        end
      end
    end
  end

  initial begin : stim
    logic [63:0] a;
    logic [63:0] b;
    tbl[0]  = '{1, 1'b1, 6'd4,  64'h8000_0000_0000_00F0, 64'h0,
                64'hF800_0000_0000_000F};
    tbl[1]  = '{2, 1'b1, 6'd0,  64'h1234_5678_9ABC_DEF0, 64'h5,
                64'h1234_5678_9ABC_DEF0};
    tbl[2]  = '{3, 1'b0, 6'd46, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'h0000_0000_0003_FFFF};
    tbl[3]  = '{0, 1'b1, 6'd46, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4]  = '{1, 1'b0, 6'd47, 64'h1111_2222_3333_4444,
                64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[5]  = '{2, 1'b1, 6'd63, 64'h8888_0000_0000_0001,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tbl[6]  = '{3, 1'b0, 6'd48, 64'hFFFF_0000_FFFF_0000,
                64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5};
    tbl[7]  = '{0, 1'b1, 6'd1,  64'h8000_0000_0000_0000, 64'h0,
                64'hC000_0000_0000_0000};
    tbl[8]  = '{1, 1'b0, 6'd1,  64'h8000_0000_0000_0000, 64'h0,
                64'h4000_0000_0000_0000};
    tbl[9]  = '{2, 1'b1, 6'd32, 64'h7FFF_FFFF_0000_0000, 64'h0,
                64'h0000_0000_7FFF_FFFF};
    tbl[10] = '{3, 1'b1, 6'd8,  64'hFF00_0000_0000_1200, 64'h0,
                64'hFFFF_0000_0000_0012};

    srst       = 1'b1;
    rsp_ready  = 1'b1;
    req_valid  = '0;
    req_signed = '0;
    req_shift  = '0;
    req_in     = '0;
    req_ex     = '0;
    for (int i = 0; i < N; i++) drv_exp[i] = '0;
    repeat (3) cyc();
    srst = 1'b0;
    cyc();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    foreach (tbl[v]) begin
      issue_one(tbl[v].rq, tbl[v].sg, tbl[v].sh, tbl[v].din,
                tbl[v].ex, tbl[v].exp);
    end
    drain();

    for (int i = 0; i < N; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      set_req(i, i[0], 6'(i * 13 + 3), a, b,
              model(i[0], 6'(i * 13 + 3), a, b));
    end
    repeat (10) cyc();
    rsp_ready = 1'b0;
    repeat (5) cyc();
    rsp_ready = 1'b1;
    repeat (4) cyc();
    req_valid = '0;
    drain();

    a = 64'h0F0F_0000_0000_F0F0;
    set_req(1, 1'b0, 6'd4, a, a, model(1'b0, 6'd4, a, a));
    set_req(2, 1'b0, 6'd8, a, a, model(1'b0, 6'd8, a, a));
    repeat (2) cyc();
    srst      = 1'b1;
    req_valid = '0;
    cyc();
    srst = 1'b0;
    cyc();
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    set_req(2, 1'b1, 6'd2, a, a, model(1'b1, 6'd2, a, a));
    set_req(0, 1'b1, 6'd3, a, a, model(1'b1, 6'd3, a, a));
    #1;
    chk("first_grant_after_rst", 64'(req_ready), 64'b0001);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    req_valid = '0;
    drain();

    b = 64'h8000_0000_1234_5678;
    issue_one(0, 1'b0, 6'd5, b, b, model(1'b0, 6'd5, b, b));
    set_req(3, 1'b1, 6'd7, b, b, model(1'b1, 6'd7, b, b));
    set_req(0, 1'b0, 6'd9, b, b, model(1'b0, 6'd9, b, b));
    #1;
    chk("sparse_grant3", 64'(req_ready), 64'b1000);
    cyc();
    chk("sparse_wrap0", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(2, 1'b0, 6'd1, b, b, 64'hBAD0_BAD0_BAD0_BAD0);
    #1;
    chk("stall_no_ready", 64'(req_ready), 64'd0);
    repeat (2) cyc();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    chk("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
